router_fifo: RTL and testbench

Per-destination packet FIFO of the 1x3 router, one instance per output port. It sits directly downstream of `router_synchronizer`: it consumes one bit of the synchronizer's `we[2:0]` and one `soft_rst_N` as write enable and soft reset. It returns `full` and `empty` to the synchronizer as `full_N` and `empty_N`. It also tags header bytes so the read side can track packet boundaries and blank `dout` between packets.

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_fifo_mem.sv | 21 ++
 rtl/router_fifo.sv | 69 ++++++
 tb/tb_router_fifo.sv | 120 ++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants and header helpers for the 1x3 router.
package router_pkg;
  localparam int DEPTH     = 16;
  localparam int WIDTH     = 8;
  localparam int PTR_W     = 4;

  // Header byte layout: {len[5:0], addr[1:0]}
  localparam int LEN_MSB   = 7;
  localparam int LEN_LSB   = 2;
  localparam int ADDR_MSB  = 1;
  localparam int ADDR_LSB  = 0;

  localparam int PKT_CNT_W = 7;

  // Bytes still to come after a header: payload length plus the parity byte.
  function automatic logic [PKT_CNT_W-1:0] hdr_cnt(input logic [LEN_MSB-LEN_LSB:0] len);
    return PKT_CNT_W'(len) + PKT_CNT_W'(1);
  endfunction

  // Destination port carried in a header byte.
  function automatic logic [ADDR_MSB-ADDR_LSB:0] hdr_addr(input logic [LEN_MSB:0] hdr);
    return hdr[ADDR_MSB:ADDR_LSB];
  endfunction
endpackage

// File: rtl/router_fifo_mem.sv
// Storage array: synchronous write, asynchronous read.
module router_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 9,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];

  // Array contents are never reset; pointers alone define validity.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/router_fifo.sv
// Per-destination packet FIFO with header tagging and idle blanking of dout.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             soft_rst,
  input  logic             we,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] din,
  input  logic             re,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  import router_pkg::*;

  logic [PTR_W:0]         wr_ptr, rd_ptr;
  logic [PKT_CNT_W-1:0]   pkt_cnt;
  logic [WIDTH:0]         rd_word;
  logic                   wr_ok, rd_ok, flush;

  // Wrap bit distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign flush = !rstn || soft_rst;
  assign wr_ok = we && !full;
  assign rd_ok = re && !empty;

  router_fifo_mem #(.DEPTH(DEPTH), .W(WIDTH+1), .AW(PTR_W)) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok && !flush),
    .wr_addr (wr_ptr[PTR_W-1:0]),
    .wr_data ({lfd_state, din}),
    .rd_addr (rd_ptr[PTR_W-1:0]),
    .rd_data (rd_word)
  );

  // Pointer advance; either reset flavour abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Read data and packet byte count; dout blanks when idle between packets.
  always_ff @(posedge clk) begin
    if (flush) begin
      dout    <= '0;
      pkt_cnt <= '0;
    end else if (rd_ok) begin
      dout <= rd_word[WIDTH-1:0];
      if (rd_word[WIDTH])
        pkt_cnt <= hdr_cnt(rd_word[LEN_MSB:LEN_LSB]);
      else if (pkt_cnt != '0)
        pkt_cnt <= pkt_cnt - PKT_CNT_W'(1);
    end else if (pkt_cnt == '0) begin
      dout <= '0;
    end
  end
endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo with a queue scoreboard of written entries.
module tb_router_fifo;
  logic       clk = 1'b0;
  logic       rstn, soft_rst, we, lfd_state, re;
  logic [7:0] din, dout;
  logic       full, empty;

  always #5 clk = ~clk;

  router_fifo dut (
    .clk       (clk),
    .rstn      (rstn),
    .soft_rst  (soft_rst),
    .we        (we),
    .lfd_state (lfd_state),
    .din       (din),
    .re        (re),
    .dout      (dout),
    .full      (full),
    .empty     (empty)
  );

  logic [8:0] sb[$];
  logic [6:0] m_pkt;
  logic [7:0] m_dout;
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, compare just after.
  task automatic step(input logic r_n, input logic sr, input logic w, input logic l,
                      input logic [7:0] d, input logic r);
    logic [8:0] e;
    bit do_rd, do_wr;
    @(negedge clk);
    rstn = r_n; soft_rst = sr; we = w; lfd_state = l; din = d; re = r;
    @(posedge clk);
    if (!r_n || sr) begin
      sb.delete();
      m_pkt  = '0;
      m_dout = '0;
    end else begin
      do_rd = r && (sb.size() > 0);
      do_wr = w && (sb.size() < 16);
      if (do_rd) begin
        e = sb.pop_front();
        m_dout = e[7:0];
        if (e[8])              m_pkt = {1'b0, e[7:2]} + 7'd1;
        else if (m_pkt != 0)   m_pkt = m_pkt - 7'd1;
      end else if (m_pkt == 0) begin
        m_dout = '0;
      end
      if (do_wr) sb.push_back({l, d});
    end
    #1;
    check("dout",  dout,          m_dout);
    check("empty", {7'b0, empty}, (sb.size() == 0)  ? 8'd1 : 8'd0);
    check("full",  {7'b0, full},  (sb.size() == 16) ? 8'd1 : 8'd0);
  endtask

  task automatic wr(input logic [7:0] d, input logic l); step(1, 0, 1, l, d, 0); endtask
  task automatic rd();   step(1, 0, 0, 0, 8'h00, 1); endtask
  task automatic idle(); step(1, 0, 0, 0, 8'h00, 0); endtask

  initial begin
    rstn = 0; soft_rst = 0; we = 0; lfd_state = 0; din = 0; re = 0;
    m_pkt = 0; m_dout = 0;

    // Reset then idle
    step(0, 0, 0, 0, 8'h00, 0);
    step(0, 0, 1, 1, 8'hEE, 1);
    repeat (5) idle();

    // One packet: header len 3, three payload bytes, parity
    wr(8'h0D, 1); wr(8'hA1, 0); wr(8'hA2, 0); wr(8'hA3, 0); wr(8'h5C, 0);
    repeat (5) rd();
    idle();

    // Fill to full, drop a 17th write, drain in order
    for (int i = 0; i < 16; i++) wr(8'(i * 7 + 3), 0);
    wr(8'hFF, 0);
    for (int i = 0; i < 16; i++) rd();
    idle();

    // Simultaneous read/write at 15 entries, then at full
    for (int i = 0; i < 15; i++) wr(8'(8'h40 + i), 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 8'(8'h80 + i), 1);
    wr(8'h90, 0);
    step(1, 0, 1, 0, 8'h91, 1);
    for (int i = 0; i < 15; i++) rd();
    rd();
    idle();

    // Soft reset mid-packet (with a write in the same cycle), then a fresh packet
    wr(8'h0D, 1); wr(8'hB1, 0); wr(8'hB2, 0); wr(8'hB3, 0); wr(8'h6E, 0);
    rd(); rd();
    step(1, 1, 1, 1, 8'hFF, 1);
    idle();
    wr(8'h05, 1); wr(8'hC1, 0); wr(8'h3A, 0);
    rd(); rd(); rd();
    idle();

    // Pointer wrap
    for (int i = 0; i < 12; i++) wr(8'(8'h10 + i), 0);
    for (int i = 0; i < 12; i++) rd();
    for (int i = 0; i < 10; i++) wr(8'(8'hD0 + i), 0);
    for (int i = 0; i < 10; i++) rd();
    repeat (2) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
